// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared funct3 encodings, LSU state encoding and access-rule
//               helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    localparam logic [1:0] c_LSU_IDLE = 2'd0;
    localparam logic [1:0] c_LSU_REQ  = 2'd1;
    localparam logic [1:0] c_LSU_WAIT = 2'd2;
    localparam logic [1:0] c_LSU_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = c_LSU_IDLE,
        S_REQ  = c_LSU_REQ,
        S_WAIT = c_LSU_WAIT,
        S_DONE = c_LSU_DONE
    } lsu_state_t;

    // Asserting both directions at once is never a supported access.
    function automatic logic f3_legal(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (ld && !st) begin
            ok = (f3 == c_F3_LB) || (f3 == c_F3_LH) || (f3 == c_F3_LW) ||
                 (f3 == c_F3_LBU) || (f3 == c_F3_LHU);
        end else if (st && !ld) begin
            ok = (f3 == c_F3_SB) || (f3 == c_F3_SH) || (f3 == c_F3_SW);
        end
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response data-memory port between the LSU (master)
//               and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Selects the addressed byte/half of a read word and sign- or
//               zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import load_store_unit_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  offset,
    input  wire logic [2:0]  funct3,
    output logic      [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            c_F3_LB:  data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  data = {{16{w_half[15]}}, w_half};
            c_F3_LBU: data = {24'd0, w_byte};
            c_F3_LHU: data = {16'd0, w_half};
            default:  data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage: one request/response transaction per
//               load/store, pipeline stall, load extraction, fault pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic              is_load,
    input  wire logic              is_store,
    input  wire logic [2:0]        funct3,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [31:0]       store_data,
    input  wire logic              flush,
    load_store_unit_if.master      mem,
    output logic                   stall,
    output logic                   out_valid,
    output logic      [31:0]       loaddata,
    output logic                   misaligned,
    output logic                   illegal_access
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_killed;
    logic [31:0]       r_loaddata;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;

    logic              w_idle;
    logic              w_mem_op;
    logic              w_legal;
    logic              w_aligned;
    logic              w_accept;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_extracted;

    assign w_idle    = (r_state == S_IDLE);
    assign w_mem_op  = in_valid & (is_load | is_store);
    assign w_legal   = f3_legal(is_load, is_store, funct3);
    assign w_aligned = is_aligned(funct3[1:0], addr[1:0]);
    assign w_accept  = w_idle & w_mem_op & w_legal & w_aligned & ~flush;

    // Store lane formatting is done once at acceptance so the request
    // fields are plain registers while the memory holds off ready.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data;
            end
        endcase
        if (!is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)           w_next = S_REQ;
            S_REQ:  if (mem.mem_req_ready)  w_next = S_WAIT;
            S_WAIT: if (mem.mem_resp_valid) w_next = S_DONE;
            S_DONE:                         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_funct3 <= 3'd0;
            r_we     <= 1'b0;
            r_wstrb  <= 4'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_addr   <= addr;
            r_funct3 <= funct3;
            r_we     <= is_store;
            r_wstrb  <= w_wstrb;
            r_wdata  <= w_wdata;
        end
    end

    // A flushed op still runs to completion on the bus; only its
    // architectural effects (loaddata, out_valid) are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_killed <= 1'b0;
        end else if (w_accept || (r_state == S_DONE)) begin
            r_killed <= 1'b0;
        end else if (flush && ((r_state == S_REQ) || (r_state == S_WAIT))) begin
            r_killed <= 1'b1;
        end
    end

    load_extract u_load_extract (
        .rdata  (mem.mem_rdata),
        .offset (r_addr[1:0]),
        .funct3 (r_funct3),
        .data   (w_extracted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loaddata <= 32'd0;
        end else if ((r_state == S_WAIT) && mem.mem_resp_valid && !r_we &&
                     !r_killed && !flush) begin
            r_loaddata <= w_extracted;
        end
    end

    assign mem.mem_req_valid = (r_state == S_REQ);
    assign mem.mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem.mem_we        = r_we;
    assign mem.mem_wstrb     = r_wstrb;
    assign mem.mem_wdata     = r_wdata;

    assign out_valid      = (r_state == S_DONE) & ~r_killed;
    assign loaddata       = r_loaddata;
    assign stall          = ~rst & ((r_state == S_REQ) | (r_state == S_WAIT) | w_accept);
    assign misaligned     = ~rst & w_idle & w_mem_op & w_legal & ~w_aligned;
    assign illegal_access = ~rst & w_idle & w_mem_op & ~w_legal;

    a_no_resp_on_handshake : assert property (
        @(posedge clk) disable iff (rst)
        !((r_state == S_REQ) && mem.mem_req_ready && mem.mem_resp_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a directed
//               sequence followed by randomized accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, is_load, is_store, flush;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, out_valid, misaligned, illegal_access;
    logic [31:0] loaddata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ld   = 32'd0;

    load_store_unit_if #(.ADDR_W(32)) mif ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .is_load        (is_load),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .flush          (flush),
        .mem            (mif),
        .stall          (stall),
        .out_valid      (out_valid),
        .loaddata       (loaddata),
        .misaligned     (misaligned),
        .illegal_access (illegal_access)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
        end
    endtask

    // Reference load result from byte arithmetic on the read word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        int          nb;
        logic [63:0] v, span;
        nb = 1 << f3[1:0];
        if (nb >= 4) return rd;
        span = 64'd1 << (8 * nb);
        v = (64'(rd) >> (8 * off)) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int rdy_dly, input int rsp_dly, input int flush_at, input string tag);
        int          nb, idx;
        logic        legal, algn, killed;
        logic [7:0]  strb8;
        logic [3:0]  estrb;
        logic [31:0] ewd, eaddr;
        nb    = 1 << f3[1:0];
        legal = (ld && st) ? 1'b0 :
                ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) :
                     (f3 <= 3'd2);
        algn  = legal ? ((a % nb) == 0) : 1'b0;
        strb8 = 8'(((1 << nb) - 1) << (a % 4));
        estrb = ld ? 4'd0 : strb8[3:0];
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = 8'(sd >> (8 * (i % nb)));
        eaddr = a - (a % 4);

        tick();
        in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; store_data = sd; flush = 1'b0;
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk(tag, "stall_accept", stall, 32'(legal && algn));
        chk(tag, "illegal", illegal_access, 32'(!legal));
        chk(tag, "misaligned", misaligned, 32'(legal && !algn));
        chk(tag, "req_idle", mif.mem_req_valid, 0);

        if (!(legal && algn)) begin
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk(tag, "no_req", mif.mem_req_valid, 0);
            chk(tag, "pulse_gone", 32'(misaligned | illegal_access), 0);
            chk(tag, "no_stall", stall, 0);
            return;
        end

        killed = 1'b0;
        idx    = 0;
        for (int k = 0; k <= rdy_dly; k++) begin
            tick();
            in_valid = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
            mif.mem_req_ready = (k == rdy_dly);
            flush = (idx == flush_at);
            if (flush) killed = 1'b1;
            idx++;
            @(negedge clk);
            chk(tag, "req_valid", mif.mem_req_valid, 1);
            chk(tag, "mem_addr", mif.mem_addr, eaddr);
            chk(tag, "mem_we", mif.mem_we, 32'(st));
            chk(tag, "mem_wstrb", mif.mem_wstrb, 32'(estrb));
            if (st) chk(tag, "mem_wdata", mif.mem_wdata, ewd);
            chk(tag, "stall_req", stall, 1);
        end
        for (int k = 0; k <= rsp_dly; k++) begin
            tick();
            mif.mem_req_ready  = 1'b0;
            mif.mem_resp_valid = (k == rsp_dly);
            mif.mem_rdata      = (k == rsp_dly) ? rd : $urandom;
            flush = (idx == flush_at);
            if (flush) killed = 1'b1;
            idx++;
            @(negedge clk);
            chk(tag, "req_wait", mif.mem_req_valid, 0);
            chk(tag, "stall_wait", stall, 1);
            chk(tag, "outv_wait", out_valid, 0);
        end
        tick();
        mif.mem_resp_valid = 1'b0; mif.mem_rdata = $urandom; flush = 1'b0;
        if (ld && !killed) exp_ld = ref_load(f3, a[1:0], rd);
        @(negedge clk);
        chk(tag, "out_valid", out_valid, 32'(!killed));
        chk(tag, "stall_done", stall, 0);
        chk(tag, "loaddata", loaddata, exp_ld);
        tick();
        @(negedge clk);
        chk(tag, "outv_once", out_valid, 0);
        chk(tag, "req_after", mif.mem_req_valid, 0);
    endtask

    task automatic nonmem_op(input string tag);
        tick();
        in_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; flush = 1'b0;
        @(negedge clk);
        chk(tag, "stall", stall, 0);
        chk(tag, "pulses", 32'(misaligned | illegal_access), 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk(tag, "no_req", mif.mem_req_valid, 0);
        chk(tag, "no_out", out_valid, 0);
    endtask

    initial begin
        logic ld, st;
        logic [2:0] f3;
        int r, rd_d, rs_d, fa;

        rst = 1'b1; in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = 3'b011; addr = 32'h100; store_data = 32'd0; flush = 1'b0;
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_rdata = 32'd0;
        @(negedge clk);
        chk("reset", "illegal", illegal_access, 0);
        chk("reset", "req_valid", mif.mem_req_valid, 0);
        chk("reset", "loaddata", loaddata, 0);
        funct3 = 3'b010;
        #1;
        chk("reset", "stall", stall, 0);
        chk("reset", "wstrb", mif.mem_wstrb, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        run_op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, -1, "lw_basic");
        chk("lw_basic", "const", loaddata, 32'hDEADBEEF);
        run_op(1, 0, 3'b000, 32'h103, 0, 32'h80000000, 0, 0, -1, "lb");
        chk("lb", "const", loaddata, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h103, 0, 32'h80000000, 1, 1, -1, "lbu");
        chk("lbu", "const", loaddata, 32'h00000080);
        run_op(1, 0, 3'b001, 32'h102, 0, 32'h80000000, 0, 2, -1, "lh");
        chk("lh", "const", loaddata, 32'hFFFF8000);
        run_op(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 4, 0, -1, "sb_hold");
        run_op(0, 1, 3'b001, 32'h202, 32'hCAFEF00D, 0, 0, 1, -1, "sh");
        run_op(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, -1, "lw_misal");
        run_op(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, -1, "ld_f3_011");
        run_op(1, 1, 3'b010, 32'h100, 0, 0, 0, 0, -1, "ld_and_st");
        run_op(0, 1, 3'b100, 32'h100, 0, 0, 0, 0, -1, "st_f3_100");
        run_op(1, 0, 3'b010, 32'h104, 0, 32'h00000055, 0, 1, 1, "lw_flush");
        chk("lw_flush", "const", loaddata, 32'hFFFF8000);

        // Flush while idle keeps the op from being accepted.
        tick();
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h108; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush", "stall", stall, 0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush", "no_req", mif.mem_req_valid, 0);

        // Asynchronous reset while the request is outstanding.
        tick();
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_req", "req_before", mif.mem_req_valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_req", "req_dropped", mif.mem_req_valid, 0);
        chk("rst_req", "stall", stall, 0);
        chk("rst_req", "loaddata", loaddata, 0);
        exp_ld = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        mif.mem_resp_valid = 1'b1; mif.mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rst_req", "stray_resp_out", out_valid, 0);
        tick();
        mif.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("rst_req", "stray_resp_ld", loaddata, 0);
        chk("rst_req", "stray_resp_req", mif.mem_req_valid, 0);
        run_op(1, 0, 3'b010, 32'h300, 0, 32'h0BADF00D, 0, 0, -1, "lw_after_rst");

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                nonmem_op("rnd_nonmem");
            end else begin
                r  = $urandom_range(0, 9);
                ld = (r < 5) || (r == 9);
                st = (r >= 5);
                f3 = 3'($urandom);
                if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'({$urandom_range(0, 1), 2'b00} | $urandom_range(0, 1));
                rd_d = $urandom_range(0, 3);
                rs_d = $urandom_range(0, 3);
                fa   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rd_d + rs_d + 1) : -1;
                run_op(ld, st, f3, 32'h1000 + ($urandom & 32'hFF), $urandom, $urandom,
                       rd_d, rs_d, fa, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between execute and writeback. It takes the ALU-computed address and store data, runs one request/response transaction per load or store on the data-memory port, and stalls the pipeline until the transaction finishes. It then presents the byte-aligned, sign- or zero-extended `loaddata` and a one-cycle `out_valid` to writeback. It also detects misaligned and unsupported accesses.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: instruction present from execute.
- `is_load`  in  1: instruction is a load.
- `is_store`  in  1: instruction is a store.
- `funct3`  in  3: access size and sign (RV32I load/store encoding).
- `addr`  in  ADDR_W: effective byte address (`alu_out`).
- `store_data`  in  32: rs2 value.
- `flush`  in  1: discard the current instruction's result.
- `mem_req_valid`  out  1: memory request valid.
- `mem_req_ready`  in  1: memory accepts the request.
- `mem_addr`  out  ADDR_W: word-aligned address `{addr[ADDR_W-1:2],2'b00}`.
- `mem_we`  out  1: 1 = write.
- `mem_wstrb`  out  4: byte enables.
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_resp_valid`  in  1: response strobe; one per request, loads and stores.
- `mem_rdata`  in  32: read word.
- `stall`  out  1: hold upstream stages.
- `out_valid`  out  1: one-cycle completion to writeback.
- `loaddata`  out  32: extended load result; held until the next completion.
- `misaligned`  out  1: one-cycle pulse for a misaligned access.
- `illegal_access`  out  1: one-cycle pulse for an unsupported `funct3`.

## Operation
- States: `IDLE`, `REQ`, `WAIT`, `DONE`.
- A memory op is `in_valid & (is_load|is_store)`.
- **IDLE:**
  - A memory op with a legal `funct3` and aligned address latches `addr`, `funct3`, direction, and the computed wstrb/wdata, then moves to `REQ`.
  - A misaligned op pulses `misaligned` combinationally; an unsupported `funct3` pulses `illegal_access`. Neither issues a request, raises `stall`, or changes state.
  - Non-memory ops pass with no effect.
- **REQ:** `mem_req_valid`=1 with stable latched fields. When `mem_req_valid & mem_req_ready`, go to `WAIT`.
- **WAIT:** when `mem_resp_valid` arrives, go to `DONE`. A load also registers the extracted `mem_rdata` into `loaddata`.
- **DONE:** `out_valid`=1 for one cycle unless the op was flushed. Go to `IDLE`.
- **Alignment:**
  - Halfword requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
- **Legal funct3:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Everything else is illegal.
- **Store lanes:**
  - SB: wstrb=`4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: wstrb=`4'b0011<<{addr[1],1'b0}`, wdata = half replicated ×2.
  - SW: wstrb=`4'b1111`.
  - Loads drive wstrb=0.
- **Load extract:** select the byte by `addr[1:0]` or the half by `addr[1]`. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **Flush:**
  - In `REQ`/`WAIT`, sets a sticky `killed` flag.
  - The transaction still completes; the response is absorbed and `loaddata` is not updated.
  - `DONE` then suppresses `out_valid`.
  - Flush in `IDLE` suppresses acceptance that cycle.
- `is_load` and `is_store` both high is treated as illegal: `illegal_access` pulses.

## Timing
- Reset values: state=`IDLE`, `killed`=0, `loaddata`=0, latched fields=0.
- Under reset, every output is 0.
- Registered outputs: `mem_req_valid`, `mem_addr`/`mem_we`/`mem_wstrb`/`mem_wdata` (from latches), `out_valid` (state decode), `loaddata`.
- `stall` = (state ∈ {`REQ`,`WAIT`}) | (`IDLE` & accepted memory op). It is 0 in `DONE`, so the next instruction is presented in the cycle after `DONE`.
- Minimum latency: acceptance at cycle 0, `REQ` at 1 (ready=1), `WAIT` at 2, response at 2, `DONE`/`out_valid` at 3.
- `mem_req_valid` holds until ready; request fields must not change while waiting.
- A response arriving in the same cycle as the request handshake is not allowed (memory contract). It is checked by assertion.
- Async reset in any state aborts at once; a response after reset is ignored in `IDLE`.

## Structure
- Shared defines header, next to the existing `` `TYPE_* `` opcode-type defines, holds:
  - `` `F3_LB ``..`` `F3_LHU ``, `` `F3_SB ``..`` `F3_SW ``.
  - The state encoding `` `LSU_IDLE ``..`` `LSU_DONE ``.
- One combinational sub-module, `load_extract`, with inputs (`rdata`, `offset[1:0]`, `funct3`) and output `[31:0]`. It is reused for lane formatting checks in verification.

## Test plan
- LW at 0x100, `mem_rdata`=0xDEADBEEF, ready at once, response next cycle -> `out_valid` at cycle 3, `loaddata`=0xDEADBEEF, `stall` high for cycles 0–2.
- LB at 0x103, rdata=0x80000000 -> 0xFFFFFF80; LBU gives 0x00000080; LH at 0x102 gives 0xFFFF8000.
- SB at 0x201, `store_data`=0x12345678 -> `mem_addr`=0x200, wstrb=0010, wdata=0x78787878, `mem_we`=1; ready held low 4 cycles keeps the request fields stable.
- LW at 0x102 -> `misaligned` pulses for 1 cycle, no `mem_req_valid`, `stall`=0; `funct3`=011 load -> `illegal_access`.
- `flush` during `WAIT` of LW, response 0x55 -> no `out_valid`, `loaddata` unchanged, return to `IDLE`.
- `rst` asserted in `REQ` -> `mem_req_valid` drops asynchronously; the next LW completes normally.
